// File: rtl/dsi_lanes_distributor.sv
// DSI lanes distributor: buffers assembler words in an 8-byte FIFO and stripes
// them round-robin over 1..LANES D-PHY data lanes inside an HS burst.
module dsi_lanes_distributor #(
  parameter int LANES        = 4,
  parameter int TRAIL_CYCLES = 8
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic [31:0]          iface_write_data,
  input  logic [4:0]           iface_write_strb,
  input  logic                 iface_write_rqst,
  input  logic                 iface_last_word,
  output logic                 iface_data_rqst,
  input  logic [1:0]           lanes_number,
  output logic                 hs_rqst,
  input  logic                 phy_hs_ready,
  output logic [8*LANES-1:0]   hs_lane_data,
  output logic [LANES-1:0]     hs_lane_valid,
  output logic                 burst_done,
  output logic                 underflow_err,
  output logic                 strb_err
);

  typedef enum logic [2:0] {IDLE, HS_RQST, SEND, TRAIL, WAIT_LP} state_t;

  state_t       state, state_next;
  logic [7:0]   fifo      [8];
  logic [7:0]   fifo_next [8];
  logic [3:0]   count, count_next, remain;
  logic [2:0]   n_lanes, n_req, n_clip;
  logic [2:0]   consume, wr_bytes;
  logic         strb_bad, underflow, wr_en, last_seen;
  logic [7:0]   trail_cnt;
  logic [8*LANES-1:0] lane_data_next;
  logic [LANES-1:0]   lane_valid_next;
  logic         unused_strb;

  assign unused_strb = iface_write_strb[4];

  assign n_req  = {1'b0, lanes_number} + 3'd1;
  assign n_clip = (n_req > 3'(LANES)) ? 3'(LANES) : n_req;

  // Only contiguous-from-LSB masks are legal; anything else ships the full word.
  always_comb begin
    strb_bad = 1'b0;
    case (iface_write_strb[3:0])
      4'h0:    wr_bytes = 3'd0;
      4'h1:    wr_bytes = 3'd1;
      4'h3:    wr_bytes = 3'd2;
      4'h7:    wr_bytes = 3'd3;
      4'hF:    wr_bytes = 3'd4;
      default: begin
        wr_bytes = 3'd4;
        strb_bad = 1'b1;
      end
    endcase
  end

  always_comb begin
    consume   = 3'd0;
    underflow = 1'b0;
    if (state == SEND && phy_hs_ready) begin
      if (count >= {1'b0, n_lanes})
        consume = n_lanes;
      else if (last_seen)
        consume = count[2:0];
      else
        underflow = 1'b1;
    end
  end

  assign remain          = count - {1'b0, consume};
  assign iface_data_rqst = (state == HS_RQST || state == SEND) && !last_seen && (remain <= 4'd4);
  assign wr_en           = iface_write_rqst && iface_data_rqst;
  assign hs_rqst         = (state == HS_RQST || state == SEND || state == TRAIL);
  assign count_next      = remain + (wr_en ? {1'b0, wr_bytes} : 4'd0);

  // Head of the FIFO is entry 0: survivors shift down, new bytes land behind them.
  always_comb begin
    logic [3:0] src;
    logic [3:0] off;
    fifo_next = fifo;
    for (int i = 0; i < 8; i++) begin
      src = 4'(i) + {1'b0, consume};
      off = 4'(i) - remain;
      if (4'(i) < remain)
        fifo_next[i] = fifo[src[2:0]];
      else if (wr_en && off < {1'b0, wr_bytes})
        fifo_next[i] = iface_write_data[{off[1:0], 3'b000} +: 8];
    end
  end

  always_comb begin
    lane_data_next  = '0;
    lane_valid_next = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k < int'(consume)) begin
        lane_data_next[8*k +: 8] = fifo[k];
        lane_valid_next[k]       = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (iface_write_rqst) state_next = HS_RQST;
      HS_RQST: if (phy_hs_ready) state_next = SEND;
      SEND:    if (last_seen && remain == 4'd0) state_next = TRAIL;
      TRAIL:   if (trail_cnt <= 8'd1) state_next = WAIT_LP;
      WAIT_LP: if (!phy_hs_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) fifo[i] <= 8'd0;
      count         <= 4'd0;
      n_lanes       <= 3'd1;
      last_seen     <= 1'b0;
      trail_cnt     <= 8'd0;
      hs_lane_data  <= '0;
      hs_lane_valid <= '0;
      burst_done    <= 1'b0;
      underflow_err <= 1'b0;
      strb_err      <= 1'b0;
    end else begin
      fifo          <= fifo_next;
      count         <= count_next;
      hs_lane_data  <= lane_data_next;
      hs_lane_valid <= lane_valid_next;
      burst_done    <= (state == WAIT_LP) && !phy_hs_ready;
      underflow_err <= underflow_err | underflow;
      strb_err      <= strb_err | (wr_en & strb_bad);
      if (state == IDLE && iface_write_rqst)
        n_lanes <= n_clip;
      if (state == IDLE)
        last_seen <= 1'b0;
      else if (wr_en && iface_last_word)
        last_seen <= 1'b1;
      // Counter spans exactly TRAIL_CYCLES cycles of TRAIL with hs_rqst held.
      if (state == SEND && state_next == TRAIL)
        trail_cnt <= 8'(TRAIL_CYCLES);
      else if (state == TRAIL)
        trail_cnt <= trail_cnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_dsi_lanes_distributor.sv
// Directed bench for dsi_lanes_distributor: cycle-exact vectors with hand-computed lane output.
module tb_dsi_lanes_distributor;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [31:0] iface_write_data;
  logic [4:0]  iface_write_strb;
  logic        iface_write_rqst;
  logic        iface_last_word;
  logic        iface_data_rqst;
  logic [1:0]  lanes_number;
  logic        hs_rqst;
  logic        phy_hs_ready;
  logic [31:0] hs_lane_data;
  logic [3:0]  hs_lane_valid;
  logic        burst_done;
  logic        underflow_err;
  logic        strb_err;

  int vectors = 0;
  int miscompares = 0;

  dsi_lanes_distributor #(.LANES(4), .TRAIL_CYCLES(8)) dut (
    .clk_sys          (clk_sys),
    .rst_n            (rst_n),
    .iface_write_data (iface_write_data),
    .iface_write_strb (iface_write_strb),
    .iface_write_rqst (iface_write_rqst),
    .iface_last_word  (iface_last_word),
    .iface_data_rqst  (iface_data_rqst),
    .lanes_number     (lanes_number),
    .hs_rqst          (hs_rqst),
    .phy_hs_ready     (phy_hs_ready),
    .hs_lane_data     (hs_lane_data),
    .hs_lane_valid    (hs_lane_valid),
    .burst_done       (burst_done),
    .underflow_err    (underflow_err),
    .strb_err         (strb_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_lanes(input string tag, input logic [31:0] data, input logic [3:0] valid);
    check({tag, "_data"}, 64'(hs_lane_data), 64'(data));
    check({tag, "_valid"}, 64'(hs_lane_valid), 64'(valid));
  endtask

  // Ride out TRAIL with the PHY still ready, then drop ready and expect burst_done.
  task automatic finish_burst(input string tag);
    int guard = 0;
    while (hs_rqst === 1'b1 && guard < 64) begin
      step();
      guard++;
    end
    check({tag, "_trail_end"}, 64'(hs_rqst), 64'd0);
    phy_hs_ready = 1'b0;
    step();
    check({tag, "_burst_done"}, 64'(burst_done), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    iface_write_data = '0;
    iface_write_strb = '0;
    iface_write_rqst = 1'b0;
    iface_last_word  = 1'b0;
    lanes_number     = 2'd0;
    phy_hs_ready     = 1'b0;
    #1;
    check("rst_hs_rqst", 64'(hs_rqst), 64'd0);
    check("rst_data_rqst", 64'(iface_data_rqst), 64'd0);
    check_lanes("rst", 32'h0, 4'h0);
    check("rst_errs", 64'({burst_done, underflow_err, strb_err}), 64'd0);
    step();
    step();
    rst_n = 1'b1;

    // 1 lane, two full words, last on the second
    lanes_number = 2'd0;
    phy_hs_ready = 1'b1;
    iface_write_rqst = 1'b1;
    iface_write_data = 32'h04030201;
    iface_write_strb = 5'h0F;
    step();
    check("t1_hs_rqst", 64'(hs_rqst), 64'd1);
    check("t1_rqst_hs", 64'(iface_data_rqst), 64'd1);
    step();
    iface_write_data = 32'h08070605;
    iface_last_word  = 1'b1;
    check("t1_rqst_send", 64'(iface_data_rqst), 64'd1);
    step();
    iface_write_rqst = 1'b0;
    iface_last_word  = 1'b0;
    check_lanes("t1_b1", 32'h01, 4'h1);
    check("t1_rqst_after_last", 64'(iface_data_rqst), 64'd0);
    for (int j = 2; j <= 8; j++) begin
      step();
      check_lanes("t1_byte", 32'(j), 4'h1);
    end
    check("t1_trail0", 64'(hs_rqst), 64'd1);
    for (int t = 1; t < 8; t++) begin
      step();
      check("t1_trail_hs", 64'(hs_rqst), 64'd1);
      check("t1_trail_valid", 64'(hs_lane_valid), 64'd0);
    end
    step();
    check("t1_lp", 64'(hs_rqst), 64'd0);
    check("t1_no_done_yet", 64'(burst_done), 64'd0);
    phy_hs_ready = 1'b0;
    step();
    check("t1_done", 64'(burst_done), 64'd1);
    step();
    check("t1_done_pulse", 64'(burst_done), 64'd0);

    // 4 lanes, three back-to-back words
    lanes_number = 2'd3;
    phy_hs_ready = 1'b1;
    iface_write_rqst = 1'b1;
    iface_write_data = 32'h13121110;
    step();
    check("t2_rqst0", 64'(iface_data_rqst), 64'd1);
    step();
    iface_write_data = 32'h17161514;
    check("t2_rqst1", 64'(iface_data_rqst), 64'd1);
    step();
    check_lanes("t2_w0", 32'h13121110, 4'hF);
    iface_write_data = 32'h1B1A1918;
    iface_last_word  = 1'b1;
    check("t2_rqst2", 64'(iface_data_rqst), 64'd1);
    step();
    iface_write_rqst = 1'b0;
    iface_last_word  = 1'b0;
    check_lanes("t2_w1", 32'h17161514, 4'hF);
    step();
    check_lanes("t2_w2", 32'h1B1A1918, 4'hF);
    step();
    check("t2_trail_valid", 64'(hs_lane_valid), 64'd0);
    finish_burst("t2");

    // 2 lanes, short last word; lanes_number change mid-burst is ignored
    lanes_number = 2'd1;
    phy_hs_ready = 1'b1;
    iface_write_rqst = 1'b1;
    iface_write_data = 32'hDDCCBBAA;
    iface_write_strb = 5'h0F;
    step();
    lanes_number = 2'd3;
    step();
    iface_write_data = 32'h000000EE;
    iface_write_strb = 5'h01;
    iface_last_word  = 1'b1;
    check("t3_rqst", 64'(iface_data_rqst), 64'd1);
    step();
    iface_write_rqst = 1'b0;
    iface_last_word  = 1'b0;
    check_lanes("t3_c0", 32'h0000BBAA, 4'h3);
    step();
    check_lanes("t3_c1", 32'h0000DDCC, 4'h3);
    step();
    check_lanes("t3_c2", 32'h000000EE, 4'h1);
    check("t3_trail_hs", 64'(hs_rqst), 64'd1);
    finish_burst("t3");

    // 4 lanes, PHY ready 5 cycles late: prefetch exactly two words
    lanes_number = 2'd3;
    phy_hs_ready = 1'b0;
    iface_write_rqst = 1'b1;
    iface_write_data = 32'h23222120;
    iface_write_strb = 5'h0F;
    step();
    check("t4_rqst_a", 64'(iface_data_rqst), 64'd1);
    step();
    iface_write_data = 32'h27262524;
    check("t4_rqst_b", 64'(iface_data_rqst), 64'd1);
    step();
    iface_write_data = 32'h2B2A2928;
    iface_last_word  = 1'b1;
    check("t4_full_a", 64'(iface_data_rqst), 64'd0);
    check("t4_no_valid", 64'(hs_lane_valid), 64'd0);
    step();
    check("t4_full_b", 64'(iface_data_rqst), 64'd0);
    step();
    check("t4_full_c", 64'(iface_data_rqst), 64'd0);
    phy_hs_ready = 1'b1;
    check("t4_full_hs", 64'(iface_data_rqst), 64'd0);
    step();
    check("t4_rqst_send", 64'(iface_data_rqst), 64'd1);
    check("t4_no_valid_send", 64'(hs_lane_valid), 64'd0);
    step();
    iface_write_rqst = 1'b0;
    iface_last_word  = 1'b0;
    check_lanes("t4_w0", 32'h23222120, 4'hF);
    step();
    check_lanes("t4_w1", 32'h27262524, 4'hF);
    step();
    check_lanes("t4_w2", 32'h2B2A2928, 4'hF);
    finish_burst("t4");

    // 3 lanes, assembler withholds the second word
    lanes_number = 2'd2;
    phy_hs_ready = 1'b1;
    iface_write_rqst = 1'b1;
    iface_write_data = 32'h33323130;
    step();
    step();
    iface_write_rqst = 1'b0;
    step();
    check_lanes("t5_c0", 32'h00323130, 4'h7);
    check("t5_no_uflow", 64'(underflow_err), 64'd0);
    step();
    check("t5_gap", 64'(hs_lane_valid), 64'd0);
    check("t5_uflow", 64'(underflow_err), 64'd1);
    iface_write_rqst = 1'b1;
    iface_write_data = 32'h37363534;
    iface_last_word  = 1'b1;
    check("t5_rqst", 64'(iface_data_rqst), 64'd1);
    step();
    iface_write_rqst = 1'b0;
    iface_last_word  = 1'b0;
    check("t5_gap2", 64'(hs_lane_valid), 64'd0);
    step();
    check_lanes("t5_c1", 32'h00353433, 4'h7);
    step();
    check_lanes("t5_c2", 32'h00003736, 4'h3);
    check("t5_uflow_sticky", 64'(underflow_err), 64'd1);
    finish_burst("t5");

    // Zero-payload last word: straight to TRAIL, nothing emitted
    lanes_number = 2'd1;
    phy_hs_ready = 1'b1;
    iface_write_rqst = 1'b1;
    iface_write_data = 32'h0;
    iface_write_strb = 5'h00;
    iface_last_word  = 1'b1;
    step();
    step();
    iface_write_rqst = 1'b0;
    iface_last_word  = 1'b0;
    check("t7_rqst", 64'(iface_data_rqst), 64'd0);
    step();
    check("t7_valid", 64'(hs_lane_valid), 64'd0);
    check("t7_hs", 64'(hs_rqst), 64'd1);
    finish_burst("t7");

    // Non-contiguous strobe, then async reset during TRAIL
    lanes_number = 2'd3;
    phy_hs_ready = 1'b1;
    iface_write_rqst = 1'b1;
    iface_write_data = 32'h43424140;
    iface_write_strb = 5'h05;
    iface_last_word  = 1'b1;
    check("t6_strb_clean", 64'(strb_err), 64'd0);
    step();
    step();
    iface_write_rqst = 1'b0;
    iface_last_word  = 1'b0;
    check("t6_strb_err", 64'(strb_err), 64'd1);
    step();
    check_lanes("t6_w0", 32'h43424140, 4'hF);
    step();
    check("t6_trail_hs", 64'(hs_rqst), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_hs", 64'(hs_rqst), 64'd0);
    check_lanes("t6_rst", 32'h0, 4'h0);
    check("t6_rst_errs", 64'({burst_done, underflow_err, strb_err}), 64'd0);
    check("t6_rst_rqst", 64'(iface_data_rqst), 64'd0);
    #1;
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
